// File: rtl/single_spi_master.sv
// Single-lane SPI master: one WIDTH-bit full-duplex transfer per accepted start,
// with selectable clock polarity/phase, bit order and sck half-period divider.
module single_spi_master #(
  parameter int WIDTH     = 8,
  parameter     FIRST_BIT = "MSB",
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam bit MSB_FIRST      = (FIRST_BIT == "MSB");
  localparam bit SCK_IDLE       = (CPOL != 0);
  localparam bit SAMPLE_ON_LEAD = (CPHA == 0);
  localparam int CW             = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ECW            = $clog2(2 * WIDTH);
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [ECW-1:0] EDGE_LAST = ECW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t           state_q;
  logic [CW-1:0]    div_q;
  logic [ECW-1:0]   edge_q;
  logic [WIDTH-1:0] tx_sh_q;
  logic [WIDTH-1:0] rx_sh_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             busy_q;
  logic             done_q;
  logic             sck_q;
  logic             cs_q;
  logic             mosi_q;

  logic             tick;
  logic             sample_edge;
  logic [WIDTH-1:0] tx_shift_d;
  logic [WIDTH-1:0] rx_shift_d;
  logic             tx_head_d;
  logic             tx_first_d;

  // edge_q counts edges already produced, so an even count means the next edge is leading.
  assign tick        = (div_q == DIV_LAST);
  assign sample_edge = SAMPLE_ON_LEAD ? ~edge_q[0] : edge_q[0];
  assign tx_shift_d  = MSB_FIRST ? {tx_sh_q[WIDTH-2:0], 1'b0} : {1'b0, tx_sh_q[WIDTH-1:1]};
  assign rx_shift_d  = MSB_FIRST ? {rx_sh_q[WIDTH-2:0], miso} : {miso, rx_sh_q[WIDTH-1:1]};
  assign tx_head_d   = MSB_FIRST ? tx_sh_q[WIDTH-1] : tx_sh_q[0];
  assign tx_first_d  = MSB_FIRST ? tx_data[WIDTH-1] : tx_data[0];

  // start is a request that is accepted on any clock where busy is low (including the done cycle);
  // there is no back-pressure beyond busy, and requests while busy are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= SCK_IDLE;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q  <= '0;
          edge_q <= '0;
          if (start) begin
            state_q <= SETUP;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            rx_sh_q <= '0;
            if (SAMPLE_ON_LEAD) begin
              mosi_q  <= tx_first_d;
              tx_sh_q <= MSB_FIRST ? {tx_data[WIDTH-2:0], 1'b0} : {1'b0, tx_data[WIDTH-1:1]};
            end else begin
              tx_sh_q <= tx_data;
            end
          end
        end
        SETUP, TRANSFER: begin
          if (tick) begin
            div_q  <= '0;
            sck_q  <= ~sck_q;
            edge_q <= edge_q + ECW'(1);
            if (sample_edge) begin
              rx_sh_q <= rx_shift_d;
            end else begin
              mosi_q  <= tx_head_d;
              tx_sh_q <= tx_shift_d;
            end
            state_q <= (edge_q == EDGE_LAST) ? HOLD : TRANSFER;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        HOLD: begin
          if (tick) begin
            div_q     <= '0;
            state_q   <= IDLE;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            mosi_q    <= 1'b0;
            rx_data_q <= rx_sh_q;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_single_spi_master.sv
// Bench for single_spi_master: four configurations side by side, a bus monitor
// measuring cs/sck timing and captured mosi bits, and an rx scoreboard.
module tb_single_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: 8b MSB mode0 div2, loopback
  logic        start_a = 1'b0, busy_a, done_a, sck_a, cs_a, mosi_a;
  logic [7:0]  tx_a = '0, rx_a;
  // instance B: 12b LSB mode1 div3, miso tied high
  logic        start_b = 1'b0, busy_b, done_b, sck_b, cs_b, mosi_b;
  logic [11:0] tx_b = '0, rx_b;
  // instance C: 16b MSB mode2 div1, bench slave
  logic        start_c = 1'b0, busy_c, done_c, sck_c, cs_c, mosi_c;
  logic        miso_c = 1'b0;
  logic [15:0] tx_c = '0, rx_c;
  // instance D: 32b MSB mode3 div2
  logic        start_d = 1'b0, busy_d, done_d, sck_d, cs_d, mosi_d;
  logic        miso_d = 1'b0;
  logic [31:0] tx_d = '0, rx_d;

  single_spi_master #(.WIDTH(8), .FIRST_BIT("MSB"), .CPOL(0), .CPHA(0), .CLK_DIV(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .rx_data(rx_a), .busy(busy_a),
    .done(done_a), .sck(sck_a), .cs(cs_a), .mosi(mosi_a), .miso(mosi_a));
  single_spi_master #(.WIDTH(12), .FIRST_BIT("LSB"), .CPOL(0), .CPHA(1), .CLK_DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .rx_data(rx_b), .busy(busy_b),
    .done(done_b), .sck(sck_b), .cs(cs_b), .mosi(mosi_b), .miso(1'b1));
  single_spi_master #(.WIDTH(16), .FIRST_BIT("MSB"), .CPOL(1), .CPHA(0), .CLK_DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .tx_data(tx_c), .rx_data(rx_c), .busy(busy_c),
    .done(done_c), .sck(sck_c), .cs(cs_c), .mosi(mosi_c), .miso(miso_c));
  single_spi_master #(.WIDTH(32), .FIRST_BIT("MSB"), .CPOL(1), .CPHA(1), .CLK_DIV(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .tx_data(tx_d), .rx_data(rx_d), .busy(busy_d),
    .done(done_d), .sck(sck_d), .cs(cs_d), .mosi(mosi_d), .miso(miso_d));

  localparam logic [3:0] CPOL_V = 4'b1100;
  localparam logic [3:0] CPHA_V = 4'b1010;

  logic [3:0]  cs_v, sck_v, busy_v, done_v, mosi_v;
  logic [31:0] rx_w [4];
  assign cs_v   = {cs_d, cs_c, cs_b, cs_a};
  assign sck_v  = {sck_d, sck_c, sck_b, sck_a};
  assign busy_v = {busy_d, busy_c, busy_b, busy_a};
  assign done_v = {done_d, done_c, done_b, done_a};
  assign mosi_v = {mosi_d, mosi_c, mosi_b, mosi_a};
  assign rx_w[0] = 32'(rx_a);
  assign rx_w[1] = 32'(rx_b);
  assign rx_w[2] = 32'(rx_c);
  assign rx_w[3] = rx_d;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor, slave model and scoreboard ----------------
  bit          mon_en = 1'b0;
  logic [3:0]  prev_cs = 4'hF;
  logic [3:0]  prev_sck = 4'b1100;
  int          low_run [4], high_run [4], edges [4];
  int          last_low [4], last_high [4], last_edges [4], done_cnt [4];
  logic [31:0] cap [4];
  int          mosi_idle_err = 0;
  int          sl_idx = 0;
  logic [15:0] slv_word = 16'hBEEF;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mon_en) begin
        if (!prev_cs[i] && cs_v[i]) begin
          last_low[i]   = low_run[i];
          last_edges[i] = edges[i];
          high_run[i]   = 0;
        end
        if (prev_cs[i] && !cs_v[i]) begin
          last_high[i] = high_run[i];
          low_run[i]   = 0;
          edges[i]     = 0;
          cap[i]       = '0;
        end
        if (cs_v[i]) high_run[i]++;
        else low_run[i]++;
        if (sck_v[i] != prev_sck[i]) begin
          edges[i]++;
          if ((sck_v[i] != CPOL_V[i]) == !CPHA_V[i]) cap[i] = {cap[i][30:0], mosi_v[i]};
        end
        if (cs_v[i] && mosi_v[i]) mosi_idle_err++;
        if (done_v[i]) begin
          done_cnt[i]++;
          check("done_cs_high", 32'(cs_v[i]), 32'd1);
          check("done_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("rx_data", rx_w[i], exp_q.pop_front());
        end
        if (i == 2) begin
          if (prev_cs[2] && !cs_c) begin
            sl_idx = 15;
            miso_c = slv_word[15];
          end else if (!cs_c && sck_c != prev_sck[2] && sck_c == 1'b1 && sl_idx > 0) begin
            sl_idx--;
            miso_c = slv_word[sl_idx];
          end
        end
      end
      prev_cs[i]  = cs_v[i];
      prev_sck[i] = sck_v[i];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int i, input logic s, input logic [31:0] tx);
    case (i)
      0: begin start_a = s; tx_a = tx[7:0]; end
      1: begin start_b = s; tx_b = tx[11:0]; end
      2: begin start_c = s; tx_c = tx[15:0]; end
      default: begin start_d = s; tx_d = tx; end
    endcase
  endtask

  task automatic launch(input int i, input logic [31:0] tx, input logic [31:0] exp_rx, input bit push);
    @(negedge clk); #1;
    drive(i, 1'b1, tx);
    if (push) exp_q.push_back(exp_rx);
    @(negedge clk); #1;
    check("cs_fall", 32'(cs_v[i]), 32'd0);
    check("busy_set", 32'(busy_v[i]), 32'd1);
    drive(i, 1'b0, tx);
  endtask

  task automatic wait_done(input int i, input int budget);
    bit seen;
    int c0;
    seen = 1'b0;
    c0 = done_cnt[i];
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk); #1;
      if (done_cnt[i] != c0) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] w;
    int c0;
    for (int i = 0; i < 4; i++) begin
      low_run[i] = 0; high_run[i] = 0; edges[i] = 0; done_cnt[i] = 0;
      last_low[i] = 0; last_high[i] = 0; last_edges[i] = 0; cap[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_cs", 32'(cs_v[i]), 32'd1);
      check("rst_sck", 32'(sck_v[i]), 32'(CPOL_V[i]));
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_done", 32'(done_v[i]), 32'd0);
      check("rst_mosi", 32'(mosi_v[i]), 32'd0);
      check("rst_rx", rx_w[i], 32'd0);
    end

    // mode 0 loopback 0xA5
    launch(0, 32'hA5, 32'hA5, 1'b1);
    check("a_first_mosi", 32'(mosi_a), 32'd1);
    wait_done(0, 100);
    check("a_cs_low", 32'(last_low[0]), 32'd34);
    check("a_edges", 32'(last_edges[0]), 32'd16);
    check("a_mosi_seq", cap[0] & 32'hFF, 32'hA5);
    check("a_done_cnt", 32'(done_cnt[0]), 32'd1);
    check("a_sck_idle", 32'(sck_a), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("a_rx_hold", 32'(rx_a), 32'hA5);

    for (int k = 0; k < 3; k++) begin
      w = 32'($urandom_range(0, 255));
      launch(0, w, w, 1'b1);
      wait_done(0, 100);
      check("a_rand_mosi", cap[0] & 32'hFF, w);
      check("a_rand_cs_low", 32'(last_low[0]), 32'd34);
    end

    // mode 1, LSB first, miso tied high
    launch(1, 32'h3C1, 32'hFFF, 1'b1);
    wait_done(1, 200);
    check("b_cs_low", 32'(last_low[1]), 32'd75);
    check("b_edges", 32'(last_edges[1]), 32'd24);
    check("b_mosi_first6", (cap[1] >> 6) & 32'h3F, 32'h20);
    check("b_mosi_all", cap[1] & 32'hFFF, 32'h83C);

    // mode 2, divider 1, slave returns 0xBEEF
    check("c_sck_before", 32'(sck_c), 32'd1);
    w = 32'($urandom_range(0, 65535));
    launch(2, w, 32'hBEEF, 1'b1);
    wait_done(2, 100);
    check("c_cs_low", 32'(last_low[2]), 32'd33);
    check("c_edges", 32'(last_edges[2]), 32'd32);
    check("c_mosi", cap[2] & 32'hFFFF, w);
    check("c_sck_after", 32'(sck_c), 32'd1);

    // start pulsed while busy is ignored
    c0 = done_cnt[0];
    launch(0, 32'h3C, 32'h3C, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("ign_busy", 32'(busy_a), 32'd1);
    drive(0, 1'b1, 32'hC3);
    @(negedge clk); #1;
    drive(0, 1'b0, 32'hC3);
    wait_done(0, 100);
    check("ign_mosi", cap[0] & 32'hFF, 32'h3C);
    repeat (40) @(negedge clk);
    #1;
    check("ign_done_once", 32'(done_cnt[0] - c0), 32'd1);
    check("ign_cs_idle", 32'(cs_a), 32'd1);

    // start held across done: back-to-back transfers
    c0 = done_cnt[0];
    @(negedge clk); #1;
    drive(0, 1'b1, 32'h12);
    exp_q.push_back(32'h12);
    @(negedge clk); #1;
    check("b2b_cs_low1", 32'(cs_a), 32'd0);
    drive(0, 1'b1, 32'h34);
    exp_q.push_back(32'h34);
    wait_done(0, 100);
    check("b2b_mosi1", cap[0] & 32'hFF, 32'h12);
    @(negedge clk); #1;
    check("b2b_cs_low2", 32'(cs_a), 32'd0);
    check("b2b_cs_high", 32'(last_high[0]), 32'd1);
    drive(0, 1'b0, 32'h34);
    wait_done(0, 100);
    check("b2b_mosi2", cap[0] & 32'hFF, 32'h34);
    repeat (10) @(negedge clk);
    #1;
    check("b2b_done_cnt", 32'(done_cnt[0] - c0), 32'd2);
    check("b2b_idle", 32'(busy_a), 32'd0);

    // mode 3 full transfer, then reset at sck edge 5
    miso_d = 1'b1;
    launch(3, $urandom, 32'hFFFF_FFFF, 1'b1);
    wait_done(3, 400);
    check("d_cs_low", 32'(last_low[3]), 32'd130);
    c0 = done_cnt[3];
    launch(3, $urandom, 32'd0, 1'b0);
    for (int k = 0; k < 50 && edges[3] != 4; k++) begin
      @(negedge clk); #1;
    end
    check("d_edge4", 32'(edges[3]), 32'd4);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_cs", 32'(cs_d), 32'd1);
    check("abort_sck", 32'(sck_d), 32'd1);
    check("abort_busy", 32'(busy_d), 32'd0);
    check("abort_rx", rx_d, 32'd0);
    check("abort_mosi", 32'(mosi_d), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt[3] - c0), 32'd0);

    check("mosi_idle_zero", 32'(mosi_idle_err), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/single_spi_master.md
SINGLE_SPI_MASTER -- requirements
Module: single_spi_master

Interface
REQ-001 Parameter WIDTH, default 8: bits per transfer, SHALL be >= 2.
REQ-002 Parameter FIRST_BIT, default "MSB": "MSB" or "LSB", first bit on the wire for both mosi and miso.
REQ-003 Parameter CPOL, default 0: idle level of sck.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Parameter CLK_DIV, default 2: clk cycles per sck half-period, SHALL be >= 1.
REQ-006 The block SHALL have one clock, clk, and reset, rst_n, which is synchronous and active-low.
REQ-007 Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  transfer request, sampled when busy=0.
- tx_data  in  WIDTH  word to send, captured when start is accepted.
- rx_data  out  WIDTH  last received word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- sck  out  1  SPI clock.
- cs  out  1  chip select, active low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Function
REQ-008 FSM states SHALL be IDLE, SETUP, TRANSFER, HOLD; all outputs SHALL be registered.
REQ-009 IDLE: cs=1, sck=CPOL, busy=0; start=1 moves to SETUP and captures tx_data into the shift register; the next cycle has cs=0 and busy=1.
REQ-010 start while busy=1 SHALL be ignored; tx_data changes after acceptance SHALL NOT affect the transfer.
REQ-011 SETUP SHALL last CLK_DIV cycles; the first sck edge SHALL occur CLK_DIV cycles after cs falls.
REQ-012 TRANSFER SHALL produce exactly 2*WIDTH sck edges spaced CLK_DIV cycles apart, with sck ending at CPOL.
REQ-013 CPHA=0: the first bit SHALL be on mosi in the same cycle cs falls; mosi SHALL update on each trailing edge; miso SHALL be sampled on each leading edge.
REQ-014 CPHA=1: mosi SHALL update on each leading edge; miso SHALL be sampled on each trailing edge.
REQ-015 FIRST_BIT="MSB": shift out tx[WIDTH-1] first, and the first received bit SHALL land in rx[WIDTH-1]; "LSB" SHALL be the mirror.
REQ-016 HOLD SHALL last CLK_DIV cycles after the last edge; then cs=1, busy=0, done=1 for one cycle, rx_data updated in that same cycle, and the FSM returns to IDLE.
REQ-017 cs low duration SHALL be exactly (2*WIDTH+1)*CLK_DIV cycles.
REQ-018 start asserted in the done cycle SHALL be accepted, giving back-to-back transfers with cs high for exactly 1 cycle.
REQ-019 rx_data SHALL hold its value between transfers and SHALL change only in the done cycle.
REQ-020 mosi SHALL be 0 whenever cs=1.

Reset
REQ-021 rst_n=0 at a clk edge SHALL force IDLE, cs=1, sck=CPOL, mosi=0, busy=0, done=0, rx_data=0, and clear the counters and shift registers.
REQ-022 Reset mid-transfer SHALL abort without a done pulse; cs SHALL rise on the next edge.

Verification
REQ-023 WIDTH=8, MSB, CPOL=0, CPHA=0, CLK_DIV=2, miso looped to mosi, tx=0xA5 -> 16 sck edges, cs low 34 cycles, done once, rx_data=0xA5, mosi sequence 1,0,1,0,0,1,0,1.
REQ-024 WIDTH=12, LSB, CPOL=0, CPHA=1, CLK_DIV=3, tx=0x3C1, miso tied 1 -> mosi first bits 1,0,0,0,0,0, rx_data=0xFFF, cs low 75 cycles.
REQ-025 WIDTH=16, MSB, CPOL=1, CPHA=0, CLK_DIV=1, bench slave model returns 0xBEEF -> rx_data=0xBEEF, sck idles 1 before and after, cs low 33 cycles.
REQ-026 start pulsed during busy with different tx_data -> ignored; the original word is sent; exactly one done.
REQ-027 start held high across done (tx 0x12 then 0x34) -> two transfers, cs high exactly 1 cycle between, two done pulses.
REQ-028 rst_n=0 at sck edge 5 of mode 3 (WIDTH=32) -> next cycle cs=1, sck=1, busy=0, no done, rx_data=0.
